// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator: one command in via valid/ready, one
// bus read or write cycle, then one response out (read data or timeout error).
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 30,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_dat_o,
  output logic                  resp_err_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [3:0]            sel_o,
  output logic [31:0]           dat_o,
  input  logic [31:0]           dat_i,
  input  logic                  ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d;
  logic [31:0]           resp_dat_q, resp_dat_d;
  logic                  resp_err_q, resp_err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  cmd_fire;
  logic                  timeout;

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  // Ack on the same edge as the timeout takes priority in both FSM and datapath.
  assign timeout  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; reset is asynchronous so cyc_o/stb_o drop immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid_i)        state_d = BUS;
      BUS:     if (ack_i || timeout)   state_d = RESP;
      RESP:    if (resp_ready_i)       state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = (state_q == IDLE);
    cyc_o        = (state_q == BUS);
    stb_o        = (state_q == BUS);
    resp_valid_o = (state_q == RESP);
  end

  always_comb begin
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    resp_dat_d = resp_dat_q;
    resp_err_d = resp_err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          we_d  = cmd_we_i;
          adr_d = cmd_adr_i;
          sel_d = cmd_sel_i;
          dat_d = cmd_dat_i;
          cnt_d = '0;
        end
      end
      BUS: begin
        if (ack_i) begin
          resp_dat_d = we_q ? 32'h0 : dat_i;
          resp_err_d = 1'b0;
        end else if (timeout) begin
          resp_dat_d = 32'h0;
          resp_err_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_dat_d = 32'h0;
          resp_err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the bus-side registers are reset too, so adr_o/sel_o/dat_o read 0
  // before the first command rather than X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      resp_dat_q <= '0;
      resp_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      resp_dat_q <= resp_dat_d;
      resp_err_q <= resp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign we_o       = we_q;
  assign adr_o      = adr_q;
  assign sel_o      = sel_q;
  assign dat_o      = dat_q;
  assign resp_dat_o = resp_dat_q;
  assign resp_err_o = resp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with TIMEOUT=8: combinational/delayed/absent
// ack, response backpressure, mid-cycle reset and a byte-lane register responder.
module tb_wb_cmd_master;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [3:0]    cmd_sel = '0;
  logic [31:0]   cmd_dat = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_dat;
  logic          resp_err;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [3:0]    sel;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i;
  logic          ack;

  // Responder controls: combinational ack from stb, or a driven ack; register mode
  logic          ack_comb = 1'b0;
  logic          ack_drv = 1'b0;
  logic [31:0]   dat_drv = '0;
  logic          pp_mode = 1'b0;
  logic [31:0]   pp_reg = '0;

  int checks = 0;
  int errors = 0;

  assign ack   = ack_comb ? stb : ack_drv;
  assign dat_i = pp_mode ? pp_reg : dat_drv;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pp_mode && cyc && stb && we && ack) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) pp_reg[8*b +: 8] <= dat_o[8*b +: 8];
    end
  end

  wb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(8), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_dat_o(resp_dat), .resp_err_o(resp_err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command; returns after the handshake edge (stb should now be 1).
  task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    int n;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_dat = d;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    check("cmd_wait", 32'(n < 50), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic count_stb(output int n);
    n = 0;
    while (stb && n < 100) begin n++; step(); end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_done_valid", 32'(resp_valid), 32'd0);
    check("resp_done_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held;

    // Reset state
    #12;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rerr", 32'(resp_err), 32'd0);
    check("rst_rdat", resp_dat, 32'h0);
    check("rst_adr", 32'(adr), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_we", 32'(we), 32'd0);

    // Write with combinational ack: one strobe cycle
    ack_comb = 1'b1;
    send_cmd(1'b1, '0, 4'hF, 32'hDEADBEEF);
    check("wr_stb", 32'(stb), 32'd1);
    check("wr_cyc", 32'(cyc), 32'd1);
    check("wr_dat_o", dat_o, 32'hDEADBEEF);
    check("wr_sel_o", 32'(sel), 32'hF);
    check("wr_we_o", 32'(we), 32'd1);
    check("wr_busy", 32'(cmd_ready), 32'd0);
    count_stb(n);
    check("wr_stb_len", 32'(n), 32'd1);
    check("wr_rvalid", 32'(resp_valid), 32'd1);
    check("wr_rerr", 32'(resp_err), 32'd0);
    check("wr_rdat", resp_dat, 32'h0);
    finish_resp();

    // Read with ack on the 4th strobe cycle
    ack_comb = 1'b0;
    send_cmd(1'b0, 30'h155, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("rd_stb", 32'(stb), 32'd1);
      check("rd_adr", 32'(adr), 32'h155);
      if (i == 3) begin ack_drv = 1'b1; dat_drv = 32'h12345678; end
      step();
    end
    ack_drv = 1'b0; dat_drv = 32'h0;
    check("rd_stb_off", 32'(stb), 32'd0);
    check("rd_rvalid", 32'(resp_valid), 32'd1);
    check("rd_rdat", resp_dat, 32'h12345678);
    check("rd_rerr", 32'(resp_err), 32'd0);
    finish_resp();

    // Timeout with ack never asserted; read data must not leak into response
    dat_drv = 32'hCAFEF00D;
    send_cmd(1'b0, 30'h2A, 4'hF, 32'h0);
    count_stb(n);
    check("to_stb_len", 32'(n), 32'd8);
    check("to_rvalid", 32'(resp_valid), 32'd1);
    check("to_rerr", 32'(resp_err), 32'd1);
    check("to_rdat", resp_dat, 32'h0);
    finish_resp();
    check("to_err_clr", 32'(resp_err), 32'd0);

    // Ack on the 8th cycle, same edge as timeout: ack wins
    send_cmd(1'b0, 30'h2B, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("ae_stb", 32'(stb), 32'd1);
      if (i == 7) begin ack_drv = 1'b1; dat_drv = 32'hA1B2C3D4; end
      step();
    end
    ack_drv = 1'b0; dat_drv = 32'h0;
    check("ae_rvalid", 32'(resp_valid), 32'd1);
    check("ae_rerr", 32'(resp_err), 32'd0);
    check("ae_rdat", resp_dat, 32'hA1B2C3D4);
    finish_resp();

    // Backpressure: response held for 5 cycles while a new command waits
    ack_comb = 1'b1;
    dat_drv = 32'h5A5A0001;
    send_cmd(1'b0, 30'h10, 4'hF, 32'h0);
    step();
    dat_drv = 32'h0;
    held = resp_dat;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 30'h20; cmd_sel = 4'h3; cmd_dat = 32'h1111;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 32'(resp_valid), 32'd1);
      check("bp_rdat", resp_dat, 32'h5A5A0001);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      check("bp_stb", 32'(stb), 32'd0);
      step();
    end
    check("bp_hold", resp_dat, held);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_rel_ready", 32'(cmd_ready), 32'd1);
    check("bp_rel_stb", 32'(stb), 32'd0);
    check("bp_rel_rdat", resp_dat, 32'h0);
    step();
    cmd_valid = 1'b0;
    check("bp_new_stb", 32'(stb), 32'd1);
    check("bp_new_adr", 32'(adr), 32'h20);
    count_stb(n);
    check("bp_new_len", 32'(n), 32'd1);
    finish_resp();

    // Reset asserted while strobe is high
    ack_comb = 1'b0;
    send_cmd(1'b0, 30'h33, 4'hF, 32'h0);
    step();
    check("mr_stb_pre", 32'(stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_stb_async", 32'(stb), 32'd0);
    check("mr_cyc_async", 32'(cyc), 32'd0);
    step();
    check("mr_rvalid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    step();
    check("mr_ready", 32'(cmd_ready), 32'd1);
    check("mr_rvalid2", 32'(resp_valid), 32'd0);
    ack_comb = 1'b1;
    send_cmd(1'b1, 30'h4, 4'hF, 32'h77);
    count_stb(n);
    check("mr_next_len", 32'(n), 32'd1);
    check("mr_next_rvalid", 32'(resp_valid), 32'd1);
    finish_resp();

    // Back-to-back write then read against a byte-lane register, 3-cycle period
    pp_mode = 1'b1;
    resp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = '0; cmd_sel = 4'h1; cmd_dat = 32'h000000A5;
    check("b2b_rdy1", 32'(cmd_ready), 32'd1);
    step();
    check("b2b_wr_stb", 32'(stb), 32'd1);
    check("b2b_busy1", 32'(cmd_ready), 32'd0);
    cmd_we = 1'b0; cmd_sel = 4'hF; cmd_dat = 32'h0;
    step();
    check("b2b_wr_resp", 32'(resp_valid), 32'd1);
    check("b2b_busy2", 32'(cmd_ready), 32'd0);
    step();
    check("b2b_rdy2", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("b2b_rd_stb", 32'(stb), 32'd1);
    check("b2b_rd_we", 32'(we), 32'd0);
    check("b2b_busy3", 32'(cmd_ready), 32'd0);
    step();
    check("b2b_rd_resp", 32'(resp_valid), 32'd1);
    check("b2b_rd_dat", resp_dat, 32'h000000A5);
    step();
    resp_ready = 1'b0;
    check("b2b_idle", 32'(cmd_ready), 32'd1);
    check("b2b_stb_idle", 32'(stb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic single-cycle bus initiator. It accepts one command at a time on a valid/ready command port and runs the matching Wishbone read or write cycle against peripheral responders such as the parallel port. It then returns the read data, or an error status, on a valid/ready response port. It sits between a command source (debug bridge, sequencer, test host) and the peripheral Wishbone bus.

Parameters:
ADDR_WIDTH, 30, width of word address on cmd_adr_i/adr_o
TIMEOUT, 255, max cycles stb_o may stay high without ack_i before abort; 0 disables timeout
CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  block can accept command
cmd_we_i  input  1  1=write, 0=read
cmd_adr_i  input  ADDR_WIDTH  word address
cmd_sel_i  input  4  byte selects
cmd_dat_i  input  32  write data
resp_valid_o  output  1  response present
resp_ready_i  input  1  response consumer ready
resp_dat_o  output  32  read data (0 for writes and errors)
resp_err_o  output  1  1=cycle aborted by timeout
cyc_o  output  1  Wishbone cycle
stb_o  output  1  Wishbone strobe
we_o  output  1  Wishbone write enable
adr_o  output  ADDR_WIDTH  Wishbone address
sel_o  output  4  Wishbone byte selects
dat_o  output  32  Wishbone write data
dat_i  input  32  Wishbone read data
ack_i  input  1  Wishbone acknowledge (may be combinational from stb_o)

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE. cyc_o, stb_o, we_o, resp_valid_o, resp_err_o = 0; adr_o, sel_o, dat_o, resp_dat_o = 0; timeout counter = 0. A reset that asserts during a bus cycle drops cyc_o/stb_o immediately, with no response issued.
- FSM states: IDLE, BUS, RESP.
- IDLE: cmd_ready_o=1 (only state where it is 1). When cmd_valid_i&&cmd_ready_o: register we/adr/sel/dat onto we_o/adr_o/sel_o/dat_o, set cyc_o=stb_o=1, clear counter, go to BUS. stb_o is first high in the cycle after the handshake.
- BUS: cyc_o=stb_o=1. All outputs stay stable until the cycle ends.
  - ack_i sampled high at a rising edge: drop cyc_o/stb_o on that edge. Set resp_dat_o = dat_i if read, else 0. Set resp_err_o=0, resp_valid_o=1, go to RESP. With a combinational-ack responder, stb_o is high for exactly one cycle.
  - No ack_i: counter increments by 1 per cycle. If TIMEOUT!=0 and the counter equals TIMEOUT-1 at the edge (stb_o has been high TIMEOUT cycles), drop cyc_o/stb_o. Set resp_err_o=1, resp_dat_o=0, resp_valid_o=1, go to RESP.
  - ack_i and timeout on the same edge: ack wins, err=0.
  - ack_i while not in BUS is ignored.
- RESP: resp_valid_o=1 and response fields held stable until resp_valid_o&&resp_ready_i. Then clear resp_valid_o, resp_err_o and resp_dat_o, and go to IDLE. A new command is accepted no earlier than the cycle after the response handshake. Minimum command-to-command period is 3 cycles with a combinational ack.
- we_o, adr_o, sel_o, dat_o retain their last values after the cycle; only cyc_o/stb_o qualify them.
- Counter saturates; it never wraps within BUS.

Test Plan:
- Write, combinational ack (ack_i=stb_o): cmd we=1, adr=0, sel=4'hF, dat=32'hDEADBEEF -> stb_o high exactly 1 cycle with dat_o=32'hDEADBEEF, sel_o=4'hF; next cycle resp_valid_o=1, resp_err_o=0, resp_dat_o=0.
- Read, ack delayed 3 cycles, dat_i=32'h12345678 at ack -> stb_o high 4 cycles, adr_o stable; resp_dat_o=32'h12345678, resp_err_o=0.
- Timeout, TIMEOUT=8, ack_i tied 0 -> stb_o high exactly 8 cycles then 0; resp_valid_o=1, resp_err_o=1, resp_dat_o=0. With ack_i on the 8th cycle instead -> err=0, data captured.
- Backpressure: resp_ready_i held 0 for 5 cycles after response -> resp_valid_o and resp_dat_o stable for 5 cycles, cmd_ready_o=0; a second cmd_valid_i is held off until the cycle after resp_ready_i=1.
- Reset mid-cycle: rst_ni pulsed low while stb_o=1 -> cyc_o/stb_o go 0 asynchronously, no resp_valid_o; after release cmd_ready_o=1 and the next command completes normally.
- Back-to-back: write 32'h000000A5 sel=4'h1 to adr 0, then read adr 0 from a parallel-port-style responder -> read returns 32'h000000A5; cmd_ready_o pulses once per transaction.
